// File: rtl/multdiv_pkg.sv
// multdiv_pkg: types and constants shared by the iterative multiply/divide
// unit and the writeback exception stage.
//   state_t     - sequencer states of multdiv
//   ITER_COUNT  - iterations per operation (one per operand bit)
//   RSTATUS_*   - exception codes written to the rstatus register
//   REG_RSTATUS - architectural register that receives rstatus codes
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ITER_COUNT = 32;

  localparam logic [31:0] RSTATUS_ADD  = 32'd1;
  localparam logic [31:0] RSTATUS_ADDI = 32'd2;
  localparam logic [31:0] RSTATUS_SUB  = 32'd3;
  localparam logic [31:0] RSTATUS_MUL  = 32'd4;
  localparam logic [31:0] RSTATUS_DIV  = 32'd5;

  localparam logic [4:0] REG_RSTATUS = 5'd30;

endpackage

// File: rtl/multdiv_div_iter.sv
// div_iter: one restoring-division step on unsigned magnitudes. Shifts the
// next dividend bit into the partial remainder and subtracts the divisor
// when it fits, shifting the resulting quotient bit in at the bottom.
//   rem_in/rem_out - partial remainder before/after the step
//   quo_in/quo_out - dividend bits still to consume, quotient bits collected
//   divisor        - unsigned divisor magnitude
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // One extra bit so the compare is exact even when the divisor is >= 2^(W-1).
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, divisor});

  always_comb begin
    rem_out = shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
    if (fits) begin
      rem_out = WIDTH'(shifted - {1'b0, divisor});
    end
  end

endmodule

// File: rtl/multdiv.sv
// multdiv: iterative signed multiply / divide unit for the execute stage.
// Multiply uses radix-2 Booth (one step per cycle), divide uses restoring
// division on magnitudes with a final sign fix. Fixed latency of WIDTH
// cycles from the start edge, then a one-cycle DONE with a ready strobe.
//   clock, reset_n          - clock (rising edge), async active-low reset
//   data_operandA/B         - multiplicand/dividend, multiplier/divisor
//   ctrl_MULT, ctrl_DIV     - start pulses, sampled in IDLE or DONE only
//   data_result             - product low word or quotient (registered)
//   data_exception          - mult overflow / div-by-zero / div overflow
//   data_is_div             - completed op was a divide
//   data_resultRDY          - one-cycle completion strobe
//   busy                    - high from start edge through the ready cycle
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic signed [WIDTH-1:0] data_operandA,
  input  logic signed [WIDTH-1:0] data_operandB,
  input  logic                    ctrl_MULT,
  input  logic                    ctrl_DIV,
  output logic        [WIDTH-1:0] data_result,
  output logic                    data_exception,
  output logic                    data_is_div,
  output logic                    data_resultRDY,
  output logic                    busy
);

  localparam int                CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Booth accumulator: {hi (W+1 bits), lo = multiplier (W bits), q_-1}.
  // hi carries a guard bit so adding/subtracting the most negative
  // multiplicand cannot overflow before the arithmetic shift.
  logic signed [WIDTH-1:0]   mcand;
  logic signed [WIDTH:0]     mcand_x;
  logic signed [WIDTH:0]     booth_hi;
  logic signed [2*WIDTH+1:0] prod;
  logic signed [2*WIDTH+1:0] prod_nxt;

  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             neg_q, div_zero, div_ovf;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    return v[WIDTH-1] ? WIDTH'(-v) : v;
  endfunction

  function automatic logic mul_ovf(input logic signed [2*WIDTH-1:0] p);
    return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
  endfunction

  function automatic logic [WIDTH-1:0] div_fix(input logic [WIDTH-1:0] q,
                                               input logic neg,
                                               input logic dz);
    if (dz) return '0;
    return neg ? WIDTH'(-q) : q;
  endfunction

  assign accept  = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
  assign mcand_x = {mcand[WIDTH-1], mcand};

  always_comb begin
    booth_hi = prod[2*WIDTH+1:WIDTH+1];
    case (prod[1:0])
      2'b01:   booth_hi = booth_hi + mcand_x;
      2'b10:   booth_hi = booth_hi - mcand_x;
      default: booth_hi = prod[2*WIDTH+1:WIDTH+1];
    endcase
    prod_nxt = $signed({booth_hi, prod[WIDTH:0]}) >>> 1;
  end

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvsr),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // Iteration datapath: loaded on accept, stepped once per busy cycle.
  always_ff @(posedge clock) begin
    if (accept) begin
      mcand    <= data_operandA;
      prod     <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
      rem      <= '0;
      quo      <= mag(data_operandA);
      dvsr     <= mag(data_operandB);
      neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
      div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (data_operandB == {WIDTH{1'b1}});
    end else if (state == MULT) begin
      prod <= prod_nxt;
    end else if (state == DIV) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

  // Sequencer and registered outputs. DONE accepts a new start so that
  // back-to-back operations issue every WIDTH+1 cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_is_div    <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE, DONE: begin
          cnt <= '0;
          if (ctrl_MULT) begin
            state <= MULT;
            busy  <= 1'b1;
          end else if (ctrl_DIV) begin
            state <= DIV;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        MULT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_result    <= prod_nxt[WIDTH:1];
            data_exception <= mul_ovf(prod_nxt[2*WIDTH:1]);
            data_is_div    <= 1'b0;
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_result    <= div_fix(quo_nxt, neg_q, div_zero);
            data_exception <= div_zero | div_ovf;
            data_is_div    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: expected results are queued when an
// operation is started and compared when the ready strobe appears.
module tb_multdiv;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [31:0] op_a = '0;
  logic signed [31:0] op_b = '0;
  logic               ctrl_MULT = 1'b0;
  logic               ctrl_DIV = 1'b0;
  logic [31:0]        data_result;
  logic               data_exception;
  logic               data_is_div;
  logic               data_resultRDY;
  logic               busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic        is_div;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_is_div    (data_is_div),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic mul, input logic signed [31:0] x,
                                 input logic signed [31:0] y);
    exp_t   e;
    longint px;
    longint py;
    longint p;
    e.is_div = !mul;
    e.cyc    = 0;
    e.tag    = "";
    if (mul) begin
      px    = x;
      py    = y;
      p     = px * py;
      e.res = p[31:0];
      e.exc = (p[63:32] != {32{p[31]}});
    end else if (y == 0) begin
      e.res = 32'h0;
      e.exc = 1'b1;
    end else if (x == 32'sh80000000 && y == -32'sd1) begin
      e.res = 32'h80000000;
      e.exc = 1'b1;
    end else begin
      e.res = x / y;
      e.exc = 1'b0;
    end
    return e;
  endfunction

  // Called at a falling edge; the start is taken at the next rising edge
  // (E0) and ready must be seen at the falling edge just after E32.
  task automatic start_op(input string tag, input logic mul,
                          input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e     = model(mul, x, y);
    e.tag = tag;
    e.cyc = cyc + 33;
    op_a      = x;
    op_b      = y;
    ctrl_MULT = mul;
    ctrl_DIV  = !mul;
    sb.push_back(e);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clock);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic mul,
                        input logic [31:0] x, input logic [31:0] y);
    start_op(tag, mul, x, y);
    wait_done(tag);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && data_resultRDY) begin
      if (sb.size() == 0) begin
        check("spurious_rdy", 32'(data_resultRDY), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_res"}, data_result, e.res);
        check({e.tag, "_exc"}, 32'(data_exception), 32'(e.exc));
        check({e.tag, "_isdiv"}, 32'(data_is_div), 32'(e.is_div));
        check({e.tag, "_lat"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_result", data_result, 32'h0);
    check("rst_exc", 32'(data_exception), 32'd0);
    check("rst_isdiv", 32'(data_is_div), 32'd0);
    check("rst_rdy", 32'(data_resultRDY), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op("mul_6x-7", 1'b1, 32'h00000006, 32'hFFFFFFF9);
    run_op("mul_ovf", 1'b1, 32'h00010000, 32'h00010000);
    run_op("mul_max", 1'b1, 32'h7FFFFFFF, 32'h00000001);
    run_op("mul_minmin", 1'b1, 32'h80000000, 32'h80000000);
    run_op("mul_minx1", 1'b1, 32'h80000000, 32'h00000001);
    run_op("div_-43/5", 1'b0, 32'hFFFFFFD5, 32'h00000005);
    run_op("div_100/-7", 1'b0, 32'd100, 32'hFFFFFFF9);
    run_op("div_by0", 1'b0, 32'd7, 32'h0);
    run_op("div_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF);
    run_op("div_min/7", 1'b0, 32'h80000000, 32'd7);
    for (int i = 0; i < 4; i++) begin
      run_op("mul_rand", 1'b1, $urandom, $urandom);
      run_op("div_rand", 1'b0, $urandom, $urandom >> $urandom_range(0, 31));
    end

    // Divide pulse mid-multiply is ignored; a start at E33 is accepted.
    start_op("mul_conflict", 1'b1, 32'd123456, 32'hFFFFFCEB);
    repeat (9) @(negedge clock);
    check("conflict_busy", 32'(busy), 32'd1);
    op_a     = 32'd5;
    op_b     = 32'd0;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (22) @(negedge clock);
    start_op("mul_b2b", 1'b1, 32'hFFFFF448, 32'd7);
    wait_done("b2b");

    // Asynchronous reset in the middle of a divide.
    run_op("div_pre", 1'b0, 32'hFFFFFFD5, 32'h00000005);
    start_op("div_abort", 1'b0, 32'd1000, 32'd3);
    repeat (14) @(negedge clock);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("arst_result", data_result, 32'h0);
    check("arst_exc", 32'(data_exception), 32'd0);
    check("arst_isdiv", 32'(data_is_div), 32'd0);
    check("arst_rdy", 32'(data_resultRDY), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("arst_after_busy", 32'(busy), 32'd0);
    run_op("mul_3x4", 1'b1, 32'd3, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
